// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: Op codes, FSM states and
// small decode helpers used by both the controller and the datapath.
package muldiv_pkg;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFix
  } state_e;

  function automatic logic is_arith_op(input logic [2:0] op);
    return !op[2];
  endfunction

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_core.sv
// Multiply/divide datapath: operand magnitudes, shift-add / restoring-divide step
// and the combinational sign correction presented to the HI/LO registers.
module muldiv_core
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic             i_step,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic             o_is_div,
  output logic             o_div_zero
);

  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] w_acc_next;
  logic [WIDTH-1:0]   r_b;
  logic               r_is_div;
  logic               r_neg_q;
  logic               r_neg_r;

  logic               w_signed;
  logic               w_neg_a;
  logic               w_neg_b;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;

  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_diff;

  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;

  always_comb begin
    w_signed = is_signed_op(i_op);
    w_neg_a  = w_signed & i_a[WIDTH-1];
    w_neg_b  = w_signed & i_b[WIDTH-1];
    w_mag_a  = w_neg_a ? -i_a : i_a;
    w_mag_b  = w_neg_b ? -i_b : i_b;
  end

  // Multiply: acc = {partial, multiplier}. Divide: acc = {remainder, dividend/quotient}.
  always_comb begin
    w_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : '0);
    w_shift = r_acc[2*WIDTH-1:WIDTH-1];
    w_diff  = w_shift - {1'b0, r_b};
    if (!r_is_div) begin
      w_acc_next = {w_sum, r_acc[WIDTH-1:1]};
    end else if (!w_diff[WIDTH]) begin
      w_acc_next = {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
    end else begin
      w_acc_next = {w_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc    <= '0;
      r_b      <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
    end else if (i_load) begin
      r_acc    <= {{WIDTH{1'b0}}, w_mag_a};
      r_b      <= w_mag_b;
      r_is_div <= is_div_op(i_op);
      r_neg_q  <= w_neg_a ^ w_neg_b;
      r_neg_r  <= w_neg_a;
    end else if (i_step) begin
      r_acc    <= w_acc_next;
    end
  end

  always_comb begin
    w_prod     = r_neg_q ? -r_acc : r_acc;
    w_quo      = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    w_rem      = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    o_is_div   = r_is_div;
    o_div_zero = r_is_div && (r_b == '0);
    if (r_is_div) begin
      // The remainder of a zero divide already equals the original dividend.
      o_hi = w_rem;
      o_lo = o_div_zero ? '1 : w_quo;
    end else begin
      o_hi = w_prod[2*WIDTH-1:WIDTH];
      o_lo = w_prod[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/alu_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; controller FSM around muldiv_core
// with a Start/Busy/Done handshake and direct MTHI/MTLO writes.
module alu_muldiv
  import muldiv_pkg::*;
#(
  parameter int unsigned  WIDTH = 32,
  localparam int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             CLK,
  input  logic             Reset_L,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] BusA,
  input  logic [WIDTH-1:0] BusB,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  state_e           r_state;
  state_e           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_done;
  logic             r_div_zero;

  logic             w_load;
  logic             w_step;
  logic             w_fix;
  logic             w_idle_start;
  logic [WIDTH-1:0] w_res_hi;
  logic [WIDTH-1:0] w_res_lo;
  logic             w_is_div;
  logic             w_div_zero;

  assign w_idle_start = (r_state == StIdle) && Start;

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_step       = 1'b0;
    w_fix        = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (Start && is_arith_op(Op)) begin
          w_load       = 1'b1;
          w_state_next = StRun;
        end
      end
      StRun: begin
        w_step = 1'b1;
        if (r_cnt == CNT_W'(1)) w_state_next = StFix;
      end
      StFix: begin
        w_fix        = 1'b1;
        w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      r_state <= StIdle;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_load) begin
        r_cnt <= CNT_W'(WIDTH);
      end else if (w_step) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

  // HI/LO change only as a whole, at the end of FIX or on an idle MTHI/MTLO.
  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      r_hi       <= '0;
      r_lo       <= '0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_fix) begin
        r_hi   <= w_res_hi;
        r_lo   <= w_res_lo;
        r_done <= 1'b1;
        if (w_is_div) r_div_zero <= w_div_zero;
      end else if (w_idle_start && (Op == OP_MTHI)) begin
        r_hi   <= BusA;
        r_done <= 1'b1;
      end else if (w_idle_start && (Op == OP_MTLO)) begin
        r_lo   <= BusA;
        r_done <= 1'b1;
      end
    end
  end

  muldiv_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .i_clk      (CLK),
    .i_rst_n    (Reset_L),
    .i_load     (w_load),
    .i_step     (w_step),
    .i_op       (Op),
    .i_a        (BusA),
    .i_b        (BusB),
    .o_hi       (w_res_hi),
    .o_lo       (w_res_lo),
    .o_is_div   (w_is_div),
    .o_div_zero (w_div_zero)
  );

  assign Busy    = (r_state != StIdle);
  assign Done    = r_done;
  assign DivZero = r_div_zero;
  assign Hi      = r_hi;
  assign Lo      = r_lo;

endmodule

// File: tb/tb_alu_muldiv.sv
// Scoreboard bench for alu_muldiv: directed ops push hand-computed HI/LO/DivZero,
// a negedge monitor pops and compares on every Done pulse.
module tb_alu_muldiv;

  localparam int unsigned W = 32;

  logic         CLK;
  logic         Reset_L;
  logic         Start;
  logic [2:0]   Op;
  logic [W-1:0] BusA;
  logic [W-1:0] BusB;
  logic         Busy;
  logic         Done;
  logic         DivZero;
  logic [W-1:0] Hi;
  logic [W-1:0] Lo;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  alu_muldiv #(
    .WIDTH (W)
  ) dut (
    .CLK     (CLK),
    .Reset_L (Reset_L),
    .Start   (Start),
    .Op      (Op),
    .BusA    (BusA),
    .BusB    (BusB),
    .Busy    (Busy),
    .Done    (Done),
    .DivZero (DivZero),
    .Hi      (Hi),
    .Lo      (Lo)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every Done pulse must match the oldest outstanding expectation.
  always @(negedge CLK) begin
    if (Reset_L && Done) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 64'(Done), 64'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("hi", 64'(Hi), 64'(e.hi));
        check("lo", 64'(Lo), 64'(e.lo));
        check("divzero", 64'(DivZero), 64'(e.dz));
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    Op    = op;
    BusA  = a;
    BusB  = b;
    Start = 1'b1;
  endtask

  task automatic expect_res(input logic [W-1:0] hi, input logic [W-1:0] lo, input logic dz);
    exp_t e;
    e.hi = hi;
    e.lo = lo;
    e.dz = dz;
    sb_q.push_back(e);
  endtask

  // Called right after issue(); returns at the negedge where Done is seen.
  task automatic wait_done(input int lat, input bit spur, input string name);
    int busy_n;
    int done_at;
    busy_n  = 0;
    done_at = 0;
    for (int n = 1; n <= 100 && done_at == 0; n++) begin
      @(negedge CLK);
      if (spur && n >= 3 && n <= 5) begin
        Start = 1'b1;
        Op    = 3'b001;
        BusA  = $urandom;
        BusB  = $urandom;
      end else begin
        Start = 1'b0;
      end
      if (Busy) busy_n++;
      if (Done) done_at = n;
    end
    check({name, "_latency"}, 64'(done_at), 64'(lat));
    check({name, "_busy_cycles"}, 64'(busy_n), 64'(lat - 1));
  endtask

  initial begin
    int done_n;
    int busy_n;
    Reset_L = 1'b0;
    Start   = 1'b0;
    Op      = '0;
    BusA    = '0;
    BusB    = '0;
    repeat (2) @(negedge CLK);
    check("rst_busy", 64'(Busy), 64'd0);
    check("rst_done", 64'(Done), 64'd0);
    check("rst_divzero", 64'(DivZero), 64'd0);
    check("rst_hi", 64'(Hi), 64'd0);
    check("rst_lo", 64'(Lo), 64'd0);
    Reset_L = 1'b1;
    @(negedge CLK);

    issue(3'b000, 32'hFFFF_FFFE, 32'h0000_0003);
    expect_res(32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0);
    wait_done(W + 2, 1'b0, "mult");

    // Issued in the Done cycle of the previous op.
    issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    expect_res(32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    wait_done(W + 2, 1'b0, "multu");

    issue(3'b010, 32'hFFFF_FFF9, 32'h0000_0002);
    expect_res(32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    wait_done(W + 2, 1'b0, "div_neg");

    issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
    expect_res(32'h0000_0000, 32'h8000_0000, 1'b0);
    wait_done(W + 2, 1'b0, "div_ovf");

    issue(3'b011, 32'h1234_5678, 32'h0000_0000);
    expect_res(32'h1234_5678, 32'hFFFF_FFFF, 1'b1);
    wait_done(W + 2, 1'b1, "divu_zero");

    issue(3'b011, 32'd100, 32'd7);
    expect_res(32'd2, 32'd14, 1'b0);
    wait_done(W + 2, 1'b0, "divu");

    issue(3'b010, 32'hFFFF_FFFB, 32'h0000_0000);
    expect_res(32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1);
    wait_done(W + 2, 1'b0, "div_zero_signed");

    issue(3'b101, 32'hA5A5_A5A5, 32'h0);
    expect_res(32'hFFFF_FFFB, 32'hA5A5_A5A5, 1'b1);
    wait_done(1, 1'b0, "mtlo");

    issue(3'b100, 32'h0BAD_F00D, 32'h0);
    expect_res(32'h0BAD_F00D, 32'hA5A5_A5A5, 1'b1);
    wait_done(1, 1'b0, "mthi");

    // Multiply leaves DivZero untouched; zero product of a negative is plain zero.
    issue(3'b000, 32'h0000_0000, 32'hFFFF_FFFB);
    expect_res(32'h0, 32'h0, 1'b1);
    wait_done(W + 2, 1'b0, "mult_zero");

    issue(3'b010, 32'hFFFF_FFFC, 32'h0000_0002);
    expect_res(32'h0, 32'hFFFF_FFFE, 1'b0);
    wait_done(W + 2, 1'b0, "div_exact");

    issue(3'b110, 32'h1111_1111, 32'h2222_2222);
    done_n = 0;
    busy_n = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge CLK);
      Start = 1'b0;
      if (Done) done_n++;
      if (Busy) busy_n++;
    end
    check("undef_op_done", 64'(done_n), 64'd0);
    check("undef_op_busy", 64'(busy_n), 64'd0);

    // Reset mid-RUN: the in-flight MULT must never complete.
    issue(3'b000, 32'h0000_1234, 32'h0000_5678);
    for (int n = 0; n < 5; n++) begin
      @(negedge CLK);
      Start = 1'b0;
    end
    Reset_L = 1'b0;
    @(negedge CLK);
    check("midrst_busy", 64'(Busy), 64'd0);
    check("midrst_done", 64'(Done), 64'd0);
    check("midrst_hi", 64'(Hi), 64'd0);
    check("midrst_lo", 64'(Lo), 64'd0);
    check("midrst_divzero", 64'(DivZero), 64'd0);
    Reset_L = 1'b1;
    @(negedge CLK);

    issue(3'b001, 32'd6, 32'd7);
    expect_res(32'd0, 32'd42, 1'b0);
    wait_done(W + 2, 1'b0, "multu_after_rst");

    repeat (5) @(negedge CLK);
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
